// File: rtl/fmap_if.sv
// Streamer bus bundle: frame request, memory read port and pixel valid/ready stream.
interface fmap_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rd_data;
    logic              pe_start;
    logic [WIDTH-1:0]  pixel_out;
    logic              pixel_out_valid;
    logic              pixel_out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, mem_rd_data, pixel_out_ready,
        output mem_rd_en, mem_addr, pe_start, pixel_out, pixel_out_valid, busy, done
    );

    modport slave (
        output start, base_addr, mem_rd_data, pixel_out_ready,
        input  mem_rd_en, mem_addr, pe_start, pixel_out, pixel_out_valid, busy, done
    );
endinterface

// File: rtl/fmap_streamer.sv
// Reads an IMG_W x IMG_H frame from memory in raster order and streams it through
// a 2-entry FIFO to a valid/ready consumer.
module fmap_streamer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = 10
) (
    input logic    clk,
    input logic    reset,
    fmap_if.master bus
);
    localparam int unsigned   N    = IMG_W * IMG_H;
    localparam int unsigned   CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              w_accept, w_rd_en, w_pop, w_push, w_room;
    logic              r_pe_start, r_inflight;
    logic [ADDR_W-1:0] r_base;
    logic [CW-1:0]     r_rd_cnt, r_out_cnt;
    logic [WIDTH-1:0]  r_mem [2];
    logic              r_wr_ptr, r_rd_ptr;
    logic [1:0]        r_count;

    assign w_pop  = (r_count != 2'd0) && bus.pixel_out_ready;
    assign w_push = r_inflight;
    // Occupancy the FIFO would reach if a read issued now, counting the in-flight return.
    assign w_room = ({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_rd_en   = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept  = 1'b1;
                    w_state_d = StStream;
                end
            end
            StStream: begin
                w_rd_en = w_room;
                if (w_rd_en && (r_rd_cnt == LAST)) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_pop && (r_out_cnt == LAST)) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pe_start <= 1'b0;
            r_inflight <= 1'b0;
            r_base     <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_pe_start <= w_accept;
            r_inflight <= w_rd_en;
            if (w_accept) begin
                r_base    <= bus.base_addr;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_pop)   r_out_cnt <= r_out_cnt + 1'b1;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.mem_rd_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.mem_rd_en       = w_rd_en;
    assign bus.mem_addr        = r_base + ADDR_W'(r_rd_cnt);
    assign bus.pe_start        = r_pe_start;
    assign bus.pixel_out       = r_mem[r_rd_ptr];
    assign bus.pixel_out_valid = (r_count != 2'd0);
    assign bus.busy            = (r_state != StIdle);
    assign bus.done            = (r_state == StDone);
endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer (4x2 frame): timing, back-pressure, wrap, reset, ignored starts.
module tb_fmap_streamer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    fmap_if #(.WIDTH(8), .ADDR_W(10)) bus ();

    fmap_streamer #(
        .WIDTH (8),
        .IMG_W (4),
        .IMG_H (2),
        .ADDR_W(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem[a] = a[7:0], one-cycle read latency.
    always_ff @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "/pe_start"}, 32'(bus.pe_start), 32'd0);
        check({tag, "/pixel_out"}, 32'(bus.pixel_out), 32'd0);
        check({tag, "/valid"}, 32'(bus.pixel_out_valid), 32'd0);
        check({tag, "/busy"}, 32'(bus.busy), 32'd0);
        check({tag, "/done"}, 32'(bus.done), 32'd0);
    endtask

    // mode 0: ready=1; 1: ready toggles 1,0,..; 2: ready=0 through cycle 20; 3: ready=1 plus stray starts
    task automatic run_frame(input string tag, input logic [9:0] base, input int mode);
        int         cyc, reads, xfers, dones, last_xfer, first_valid, last_read;
        logic       hold, rdy;
        logic [7:0] hold_pix, exp_pix;
        logic [9:0] exp_addr;
        reads = 0; xfers = 0; dones = 0; last_xfer = -10; first_valid = -1; last_read = -1;
        hold = 1'b0; hold_pix = 8'h00; cyc = 0;
        bus.base_addr = base;
        bus.start = 1'b1;
        bus.pixel_out_ready = 1'b0;
        step();
        cyc = 1;
        while (dones == 0 && cyc < 80) begin
            case (mode)
                1:       rdy = cyc[0];
                2:       rdy = (cyc > 20);
                default: rdy = 1'b1;
            endcase
            bus.pixel_out_ready = rdy;
            bus.start = (mode == 3) && (cyc == 5 || cyc == 6);
            #1;
            check({tag, "/pe_start"}, 32'(bus.pe_start), 32'(cyc == 1));
            check({tag, "/busy"}, 32'(bus.busy), 32'd1);
            if (bus.mem_rd_en) begin
                exp_addr = base + 10'(reads);
                check({tag, "/addr"}, 32'(bus.mem_addr), 32'(exp_addr));
                reads++;
                last_read = cyc;
            end
            if (hold) begin
                check({tag, "/hold_valid"}, 32'(bus.pixel_out_valid), 32'd1);
                check({tag, "/hold_pixel"}, 32'(bus.pixel_out), 32'(hold_pix));
            end
            if (mode == 2 && cyc == 20) begin
                check({tag, "/stall_reads"}, 32'(reads), 32'd2);
                check({tag, "/stall_valid"}, 32'(bus.pixel_out_valid), 32'd1);
                check({tag, "/stall_pixel"}, 32'(bus.pixel_out), 32'(base[7:0]));
            end
            if (bus.pixel_out_valid && first_valid < 0) first_valid = cyc;
            if (bus.pixel_out_valid && rdy) begin
                exp_addr = base + 10'(xfers);
                exp_pix  = exp_addr[7:0];
                check({tag, "/pixel"}, 32'(bus.pixel_out), 32'(exp_pix));
                xfers++;
                last_xfer = cyc;
            end
            check({tag, "/occupancy"}, 32'((reads - xfers) <= 2), 32'd1);
            hold     = bus.pixel_out_valid && !rdy;
            hold_pix = bus.pixel_out;
            if (bus.done) begin
                dones++;
                check({tag, "/done_latency"}, 32'(cyc), 32'(last_xfer + 1));
                check({tag, "/pixel_count"}, 32'(xfers), 32'd8);
                check({tag, "/read_count"}, 32'(reads), 32'd8);
            end else begin
                step();
                cyc++;
            end
        end
        check({tag, "/done_seen"}, 32'(dones), 32'd1);
        if (mode == 0) begin
            check({tag, "/first_valid_cyc"}, 32'(first_valid), 32'd3);
            check({tag, "/last_read_cyc"}, 32'(last_read), 32'd8);
            check({tag, "/done_cyc"}, 32'(cyc), 32'd11);
        end
        bus.start = (mode == 3);
        step();
        bus.start = 1'b0;
        bus.pixel_out_ready = 1'b1;
        #1;
        check({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "/idle_done"}, 32'(bus.done), 32'd0);
        check({tag, "/idle_pe_start"}, 32'(bus.pe_start), 32'd0);
        check({tag, "/idle_valid"}, 32'(bus.pixel_out_valid), 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.pixel_out_ready = 1'b0;
        step();
        check_outputs_zero("reset");
        step();
        reset = 1'b0;
        #1;
        check_outputs_zero("post_reset");

        run_frame("basic", 10'h010, 0);
        // Started in the same cycle IDLE is re-entered.
        run_frame("toggle", 10'h010, 1);
        run_frame("wrap", 10'h3FD, 0);
        run_frame("stall", 10'h010, 2);
        run_frame("stray_start", 10'h020, 3);

        // Abort a frame mid-stream with an asynchronous reset.
        bus.base_addr = 10'h010;
        bus.start = 1'b1;
        bus.pixel_out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        step();
        reset = 1'b0;
        #1;
        check({"after_reset", "/busy"}, 32'(bus.busy), 32'd0);
        run_frame("after_reset", 10'h030, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fmap_streamer.md
FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 32, pixels per row.
REQ-003 SHALL have parameter IMG_H, default 32, rows per frame.
REQ-004 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-008 SHALL have port base_addr  input  ADDR_W  frame base address, latched when start is accepted.
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory read address.
REQ-011 SHALL have port mem_rd_data  input  WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port pe_start  output  1  one-cycle start pulse to the downstream PE.
REQ-013 SHALL have port pixel_out  output  WIDTH  streamed pixel, raster order.
REQ-014 SHALL have port pixel_out_valid  output  1  pixel_out holds a valid pixel.
REQ-015 SHALL have port pixel_out_ready  input  1  downstream accepts pixel; transfer = valid & ready.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-018 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-019 IDLE -> STREAM on start=1; start in any other state SHALL be ignored.
REQ-020 On acceptance, SHALL latch base_addr, clear read and output counters, and assert pe_start for exactly the next cycle (cycle 1 if start in cycle 0).
REQ-021 First mem_rd_en SHALL coincide with pe_start, mem_addr = base_addr.
REQ-022 Read k (k = 0..N-1, N = IMG_W*IMG_H) SHALL use mem_addr = (base_addr + k) mod 2^ADDR_W; wrap-around is silent.
REQ-023 SHALL buffer returned data in a 2-entry FIFO; pixel_out/pixel_out_valid driven from FIFO head, registered.
REQ-024 mem_rd_en SHALL assert only while reads issued < N and (fifo_count + inflight - pop) < 2, pop = valid & ready this cycle; FIFO never overflows.
REQ-025 With pixel_out_ready held high, SHALL sustain one pixel per cycle; first pixel_out_valid in cycle 3 when start in cycle 0.
REQ-026 pixel_out and pixel_out_valid SHALL hold stable while valid=1 and ready=0.
REQ-027 STREAM -> DRAIN when read N-1 issues; DRAIN -> DONE on the cycle pixel N-1 transfers; DONE -> IDLE after one cycle.
REQ-028 done SHALL be high only in DONE; busy SHALL be low only in IDLE.
REQ-029 Pixel count SHALL be exactly N per frame; no duplicate, dropped or reordered pixels under any ready pattern.
REQ-030 Data SHALL pass unmodified (no arithmetic); counters sized ceil(log2(N+1)) bits.
REQ-031 start asserted in DONE SHALL be ignored; start in the cycle IDLE is re-entered SHALL be accepted.

Reset
REQ-032 reset=1 SHALL force, asynchronously: state IDLE, FIFO empty, inflight cleared, counters 0.
REQ-033 During reset all outputs SHALL be 0: mem_rd_en, mem_addr, pe_start, pixel_out, pixel_out_valid, busy, done.
REQ-034 Reset mid-frame SHALL abort the frame; read data returning the cycle after reset deassertion SHALL be discarded; next start begins a fresh frame.

Verification
REQ-035 IMG_W=4, IMG_H=2, base_addr=0x010, mem[i]=i, ready=1, start cycle 0 -> pe_start cycle 1, addresses 0x010..0x017 cycles 1..8, pixels 0x10..0x17 cycles 3..10, done cycle 11.
REQ-036 Same config, ready toggling 1,0,1,0... -> 8 pixels in order 0x10..0x17, pixel_out stable during ready=0, FIFO never exceeds 2, done one cycle after 8th transfer.
REQ-037 base_addr=2^ADDR_W-3, N=8 -> addresses wrap: last 3 below 2^ADDR_W, then 0..4.
REQ-038 ready=0 for 20 cycles after start -> at most 2 reads issued, pixel_out_valid=1 holding pixel 0, no data loss after ready rises.
REQ-039 reset asserted cycle 5 mid-frame -> all outputs 0 same cycle; new start after release -> pe_start and full frame from pixel 0.
REQ-040 start pulsed during STREAM and DONE -> ignored; single frame of N pixels, single done pulse.
